// File: rtl/neuron_pkg.sv
// Shared constants for the neuron pipeline blocks.
// Streamer, NeuronCore and stream_writer all use this state encoding.
package neuron_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int WORDS_DEF  = 4096;
  localparam int FDEPTH_DEF = 8;

  typedef logic [1:0] wstate_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO buffering result words ahead of the BRAM port.
// Pointers carry one extra wrap bit to tell full from empty.
module stream_fifo
  import neuron_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int FDEPTH = FDEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;

  logic [DWIDTH-1:0] mem [FDEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/stream_writer.sv
// Streams NeuronCore result words into one DualBRAM write port,
// covering the address range [START, LIMIT) with wrap at WORDS.
module stream_writer
  import neuron_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int WORDS  = WORDS_DEF,
  parameter  int FDEPTH = FDEPTH_DEF,
  localparam int SIZE   = $clog2(WORDS)
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [DWIDTH-1:0] START,
  input  logic [DWIDTH-1:0] LIMIT,
  input  logic              VALID,
  input  logic [DWIDTH-1:0] DATAI,
  output logic              READY,
  output logic              WE,
  output logic [SIZE-1:0]   ADDR,
  output logic [DWIDTH-1:0] DATAO,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVERFLOW
);

  wstate_t           state;
  logic [SIZE-1:0]   ptr;
  logic [SIZE-1:0]   ptr_nxt;
  logic [DWIDTH-1:0] total;
  logic [DWIDTH-1:0] accepted;
  logic [DWIDTH-1:0] written;
  logic [DWIDTH-1:0] head;
  logic              run;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  assign run   = (state == S_RUN);
  assign READY = run && !full && (accepted < total);
  assign push  = VALID && READY;
  assign pop   = run && !empty;
  assign BUSY  = run;
  assign DONE  = (state == S_FIN);

  assign ptr_nxt = (ptr == SIZE'(WORDS - 1)) ? '0 : ptr + SIZE'(1);

  stream_fifo #(
    .DWIDTH(DWIDTH),
    .FDEPTH(FDEPTH)
  ) u_fifo (
    .clk  (CLOCK),
    .rst  (RESET),
    .push (push),
    .pop  (pop),
    .wdata(DATAI),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      ptr      <= '0;
      total    <= '0;
      accepted <= '0;
      written  <= '0;
      WE       <= 1'b0;
      ADDR     <= '0;
      DATAO    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      WE <= pop;
      if (pop) begin
        ADDR    <= ptr;
        DATAO   <= head;
        ptr     <= ptr_nxt;
        written <= written + DWIDTH'(1);
      end
      if (push) accepted <= accepted + DWIDTH'(1);
      if (run && VALID && !READY) OVERFLOW <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (EN) begin
            ptr      <= START[SIZE-1:0];
            total    <= LIMIT - START;
            accepted <= '0;
            written  <= '0;
            OVERFLOW <= 1'b0;
            // An empty or inverted range completes without writes
            state    <= (LIMIT > START) ? S_RUN : S_FIN;
          end
        end
        S_RUN: begin
          if (written == total) state <= S_FIN;
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_writer.sv
// Scoreboard bench for stream_writer: jobs queue expected BRAM writes,
// a negedge monitor pops and compares every WE cycle.
module tb_stream_writer;

  localparam int WORDS = 4096;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic        EN = 1'b0;
  logic        VALID = 1'b0;
  logic [31:0] START = '0;
  logic [31:0] LIMIT = '0;
  logic [31:0] DATAI = '0;
  logic        READY;
  logic        WE;
  logic [11:0] ADDR;
  logic [31:0] DATAO;
  logic        BUSY;
  logic        DONE;
  logic        OVERFLOW;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  last_we_cyc = -10;
  int  we_cnt = 0;
  bit  prev_ovf = 1'b0;

  logic [31:0] fp [10] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000
  };

  stream_writer #(
    .DWIDTH(32),
    .WORDS (WORDS),
    .FDEPTH(8)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .EN      (EN),
    .START   (START),
    .LIMIT   (LIMIT),
    .VALID   (VALID),
    .DATAI   (DATAI),
    .READY   (READY),
    .WE      (WE),
    .ADDR    (ADDR),
    .DATAO   (DATAO),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .OVERFLOW(OVERFLOW)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLOCK) begin : mon
    wr_t e;
    if (WE === 1'b1) begin
      last_we_cyc = cyc;
      we_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_we", WE, 0);
      end else begin
        e = exp_q.pop_front();
        check("we_addr", ADDR, e.addr);
        check("we_data", DATAO, e.data);
      end
    end
  end

  task automatic run_job(input logic [31:0] s, input logic [31:0] l,
                         input logic [31:0] w[$], input int gap);
    logic [31:0] tot;
    int  n_acc;
    int  waitc;
    bit  ovf;
    bit  r;
    wr_t e;
    tot   = (l > s) ? l - s : 32'd0;
    n_acc = (w.size() < int'(tot)) ? w.size() : int'(tot);
    ovf   = (tot != 0) && (w.size() > n_acc);
    for (int i = 0; i < n_acc; i++) begin
      e.addr = 12'((s + 32'(i)) % WORDS);
      e.data = w[i];
      exp_q.push_back(e);
    end
    @(posedge CLOCK); #1;
    if (prev_ovf) check("overflow_sticky", OVERFLOW, 1);
    EN = 1'b1; START = s; LIMIT = l;
    @(posedge CLOCK); #1;
    EN = 1'b0; START = $urandom; LIMIT = $urandom;
    check("overflow_clr", OVERFLOW, 0);
    check("busy_start", BUSY, 32'(tot != 0));
    check("done_start", DONE, 32'(tot == 0));
    for (int i = 0; i < w.size(); i++) begin
      if (i < n_acc) begin
        while ($urandom_range(0, 99) < gap) begin
          VALID = 1'b0;
          @(posedge CLOCK); #1;
        end
        VALID = 1'b1; DATAI = w[i];
        EN = 1'($urandom_range(0, 1));
        r = 1'b0; waitc = 0;
        while (!r && waitc < 100) begin
          r = READY;
          @(posedge CLOCK); #1;
          waitc++;
        end
        EN = 1'b0;
        check("accepted", 32'(r), 1);
      end else begin
        VALID = 1'b1; DATAI = w[i];
        check("ready_beyond_total", READY, 0);
        @(posedge CLOCK); #1;
      end
    end
    VALID = 1'b0;
    if (tot != 0) begin
      waitc = 0;
      while (!DONE && waitc < 200) begin
        @(posedge CLOCK); #1;
        waitc++;
      end
      check("done_seen", DONE, 1);
      check("done_latency", cyc, last_we_cyc + 1);
      check("busy_fin", BUSY, 0);
    end
    check("pending", exp_q.size(), 0);
    check("overflow", OVERFLOW, 32'(ovf));
    @(posedge CLOCK); #1;
    check("done_pulse", DONE, 0);
    check("busy_idle", BUSY, 0);
    prev_ovf = ovf;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] w[$];
    logic [31:0] s;
    logic [31:0] l;
    int  t;
    int  x;
    int  k;
    int  base;
    int  waitc;
    bit  r;
    wr_t e;

    #1;
    check("rst_we", WE, 0);
    check("rst_addr", ADDR, 0);
    check("rst_ready", READY, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ovf", OVERFLOW, 0);
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;

    for (int i = 0; i < 10; i++) w.push_back(fp[i]);
    run_job(10, 20, w, 0);

    w.delete();
    for (int i = 0; i < 12; i++) w.push_back($urandom);
    run_job(100, 112, w, 0);

    w.delete();
    run_job(20, 20, w, 0);
    run_job(30, 5, w, 0);

    for (int i = 0; i < 4; i++) w.push_back($urandom);
    run_job(4094, 4098, w, 0);

    w.delete();
    for (int i = 0; i < 5; i++) w.push_back($urandom);
    run_job(50, 53, w, 0);

    @(posedge CLOCK); #1;
    check("overflow_sticky", OVERFLOW, 1);
    EN = 1'b1; START = 0; LIMIT = 10;
    @(posedge CLOCK); #1;
    EN = 1'b0; VALID = 1'b1; DATAI = $urandom;
    k = 0; base = we_cnt; waitc = 0;
    while (we_cnt < base + 3 && waitc < 50) begin
      r = READY;
      @(posedge CLOCK); #1;
      if (r) begin
        e.addr = 12'(k); e.data = DATAI;
        exp_q.push_back(e);
        k++; DATAI = $urandom;
      end
      waitc++;
    end
    check("rst_three_writes", we_cnt, base + 3);
    #2 RESET = 1'b1;
    #1;
    check("arst_we", WE, 0);
    check("arst_addr", ADDR, 0);
    check("arst_data", DATAO, 0);
    check("arst_busy", BUSY, 0);
    check("arst_done", DONE, 0);
    check("arst_ovf", OVERFLOW, 0);
    check("arst_ready", READY, 0);
    exp_q.delete();
    VALID = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    prev_ovf = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    check("no_we_after_rst", we_cnt, base + 3);
    w.delete();
    w.push_back($urandom); w.push_back($urandom);
    run_job(0, 2, w, 0);

    for (int j = 0; j < 12; j++) begin
      s = $urandom_range(0, 4095);
      t = $urandom_range(0, 16);
      if (t == 0 && s > 0 && $urandom_range(0, 1) == 1)
        l = $urandom_range(0, s - 1);
      else
        l = s + t;
      x = (t != 0) ? $urandom_range(0, 2) : 0;
      w.delete();
      for (int i = 0; i < t + x; i++) w.push_back($urandom);
      run_job(s, l, w, $urandom_range(0, 50));
    end

    repeat (3) @(posedge CLOCK);
    #1;
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_writer.md
STREAM_WRITER -- requirements
Module: stream_writer

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, data word width (IEEE-754 single from NeuronCore).
REQ-002 SHALL have parameter WORDS, default 4096, BRAM depth; SIZE = clog2(WORDS) address bits.
REQ-003 SHALL have parameter FDEPTH, default 8, internal FIFO depth, power of two.
REQ-004 SHALL have port CLOCK  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port EN  input  1  start request, sampled in IDLE only.
REQ-007 SHALL have port START  input  DWIDTH  first write address, latched on accepted EN.
REQ-008 SHALL have port LIMIT  input  DWIDTH  end address (exclusive), latched on accepted EN.
REQ-009 SHALL have port VALID  input  1  result word present on DATAI (NeuronCore output).
REQ-010 SHALL have port DATAI  input  DWIDTH  result word.
REQ-011 SHALL have port READY  output  1  word accepted this cycle when VALID&READY.
REQ-012 SHALL have port WE  output  1  BRAM write enable (DualBRAM WE_PORT_x).
REQ-013 SHALL have port ADDR  output  SIZE  BRAM write address.
REQ-014 SHALL have port DATAO  output  DWIDTH  BRAM write data.
REQ-015 SHALL have port BUSY  output  1  high in RUN.
REQ-016 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-017 SHALL have port OVERFLOW  output  1  sticky: VALID seen while READY low in RUN.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, FIN; IDLE->RUN on EN when LIMIT>START; IDLE->FIN on EN when LIMIT<=START (no writes); RUN->FIN when written count reaches LIMIT-START; FIN->IDLE unconditionally.
REQ-019 SHALL on accepted EN latch ptr=START[SIZE-1:0], total=LIMIT-START, accepted=0, written=0.
REQ-020 SHALL drive READY = RUN && FIFO not full && accepted<total (combinational).
REQ-021 SHALL push DATAI into FIFO on VALID&READY, incrementing accepted.
REQ-022 SHALL pop one FIFO word per cycle when RUN and FIFO non-empty, registering WE=1, ADDR=ptr, DATAO=word; ptr increments, wrapping WORDS-1 -> 0.
REQ-023 SHALL give latency 1: word accepted at edge n appears with WE=1 after edge n+1 when FIFO was empty.
REQ-024 SHALL permit simultaneous push and pop, including when full (pop frees slot; READY stays low that cycle as full is pre-edge).
REQ-025 SHALL drive WE=0 every cycle no pop occurs; ADDR/DATAO hold last values.
REQ-026 SHALL assert DONE for exactly the FIN cycle; BUSY low in IDLE and FIN.
REQ-027 SHALL ignore EN in RUN and FIN; latched START/LIMIT unaffected by input changes.
REQ-028 SHALL set OVERFLOW on VALID&!READY in RUN; cleared only by reset or accepted EN; dropped words are not written.
REQ-029 SHALL use total width DWIDTH; words beyond total are never accepted.

Reset
REQ-030 SHALL on RESET (any time, incl. mid-RUN) asynchronously force IDLE, flush FIFO, zero ptr/counters, WE=0, ADDR=0, DATAO=0, BUSY=0, DONE=0, OVERFLOW=0, READY=0.
REQ-031 SHALL resume normal operation first rising edge after RESET deasserts; no partial write pending.

Structure
REQ-032 SHALL place state encoding (IDLE/RUN/FIN) and default DWIDTH/WORDS constants in shared package neuron_pkg, shared with Streamer/NeuronCore.
REQ-033 SHALL instantiate one sub-module stream_fifo (synchronous FIFO, FDEPTH x DWIDTH, push/pop/full/empty, async active-high reset).
REQ-034 SHALL connect WE/ADDR/DATAO directly to one DualBRAM port without glue.

Verification
REQ-035 Basic: START=10, LIMIT=20, VALID held high with 1.0..10.0 -> WE at ADDR 10..19 in order, DATAO 3F800000..41200000, DONE pulse one cycle after last write, BRAM[10..19] match.
REQ-036 Backpressure: VALID held high, pop disabled-equivalent via burst of 12 words with FDEPTH=8 into total=12 -> READY never high when full, all 12 words written, OVERFLOW=0.
REQ-037 Empty range: START=20, LIMIT=20 and START=30, LIMIT=5 -> no WE, DONE pulse 2nd cycle after EN, BUSY never high.
REQ-038 Wrap: START=4094, LIMIT=4098 -> writes at ADDR 4094, 4095, 0, 1, DONE.
REQ-039 Reset mid-run: RESET asserted after 3 of 10 writes -> outputs zero immediately (asynchronous), no further WE; new EN START=0, LIMIT=2 completes normally.
REQ-040 Overflow/extra: VALID with 5 words when total=3 -> 3 writes, READY low afterwards, OVERFLOW=1 until next EN.
